imem_program_loader: RTL and testbench



---
 rtl/imem_program_loader.sv | 199 +++++++++++++++++++
 tb/tb_imem_program_loader.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Program-image loader for the 16-bit instruction memory.
// Accepts a framed byte stream (LEN, 2N data bytes low-first, CHK), writes
// assembled words to sequential addresses, verifies the additive checksum
// and keeps the CPU held until a good image is resident.
module imem_program_loader #(
   parameter int IMEM_AW     = 4,
   parameter int INSTR_W     = 16,
   parameter int TIMEOUT_CYC = 1024
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               in_valid,
   input  logic [7:0]         in_data,
   output logic               in_ready,
   output logic               imem_we,
   output logic [IMEM_AW-1:0] imem_waddr,
   output logic [INSTR_W-1:0] imem_wdata,
   output logic               cpu_hold,
   output logic               done,
   output logic               error,
   output logic [IMEM_AW:0]   words_loaded
);

   // Timer only needs to reach TIMEOUT_CYC-1; the LEN bound check assumes IMEM_AW <= 8.
   localparam int              TW         = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0]   TIMER_LAST = TW'(TIMEOUT_CYC - 1);
   localparam logic [8:0]      MAX_N      = 9'(1 << IMEM_AW);

   typedef enum logic [2:0] {
      S_IDLE, S_LEN, S_LOW, S_HIGH, S_CHK, S_DONE, S_ERR
   } state_t;

   state_t             state_q, state_d;
   logic               in_ready_q, in_ready_d;
   logic               imem_we_q, imem_we_d;
   logic [IMEM_AW-1:0] imem_waddr_q, imem_waddr_d;
   logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
   logic               cpu_hold_q, cpu_hold_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
   logic [IMEM_AW:0]   words_loaded_q, words_loaded_d;
   logic [IMEM_AW:0]   len_q, len_d;
   logic [7:0]         low_q, low_d;
   logic [IMEM_AW-1:0] addr_q, addr_d;
   logic [7:0]         sum_q, sum_d;
   logic [TW-1:0]      timer_q, timer_d;

   logic               xfer;
   logic               active;
   logic [8:0]         n_ext;
   logic [7:0]         sum_next;
   logic [IMEM_AW:0]   words_inc;

   assign xfer     = in_valid && in_ready_q;
   assign active   = (state_q == S_LEN) || (state_q == S_LOW) ||
                     (state_q == S_HIGH) || (state_q == S_CHK);
   assign n_ext    = {1'b0, in_data};
   assign sum_next = sum_q + in_data;
   assign words_inc = words_loaded_q + (IMEM_AW + 1)'(1);

   // Next-state and registered-output computation for the frame FSM.
   always_comb begin
      // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
      state_d        = state_q;
      in_ready_d     = in_ready_q;
      imem_we_d      = 1'b0;
      imem_waddr_d   = imem_waddr_q;
      imem_wdata_d   = imem_wdata_q;
      cpu_hold_d     = cpu_hold_q;
      done_d         = done_q;
      error_d        = error_q;
      words_loaded_d = words_loaded_q;
      len_d          = len_q;
      low_d          = low_q;
      addr_d         = addr_q;
      sum_d          = sum_q;
      timer_d        = timer_q;

      if (active) begin
         timer_d = xfer ? '0 : timer_q + TW'(1);
      end

      unique case (state_q)
         S_IDLE, S_DONE, S_ERR: begin
            if (start) begin
               state_d        = S_LEN;
               sum_d          = '0;
               words_loaded_d = '0;
               addr_d         = '0;
               imem_waddr_d   = '0;
               cpu_hold_d     = 1'b1;
               done_d         = 1'b0;
               error_d        = 1'b0;
               timer_d        = '0;
            end
         end
         S_LEN: begin
            if (xfer) begin
               if ((n_ext == 9'd0) || (n_ext > MAX_N)) begin
                  state_d = S_ERR;
               end else begin
                  len_d   = n_ext[IMEM_AW:0];
                  state_d = S_LOW;
               end
            end
         end
         S_LOW: begin
            if (xfer) begin
               low_d   = in_data;
               sum_d   = sum_next;
               state_d = S_HIGH;
            end
         end
         S_HIGH: begin
            if (xfer) begin
               imem_we_d      = 1'b1;
               imem_wdata_d   = {in_data, low_q};
               imem_waddr_d   = addr_q;
               addr_d         = addr_q + IMEM_AW'(1);
               sum_d          = sum_next;
               words_loaded_d = words_inc;
               state_d        = (words_inc == len_q) ? S_CHK : S_LOW;
            end
         end
         S_CHK: begin
            if (xfer) begin
               state_d = (sum_next == 8'h00) ? S_DONE : S_ERR;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // Idle too long inside a frame; a transfer on the last cycle still wins.
      if (active && !xfer && (timer_q == TIMER_LAST)) begin
         state_d = S_ERR;
      end

      if ((state_d == S_DONE) && (state_q != S_DONE)) begin
         done_d     = 1'b1;
         cpu_hold_d = 1'b0;
         timer_d    = '0;
      end
      if ((state_d == S_ERR) && (state_q != S_ERR)) begin
         error_d    = 1'b1;
         cpu_hold_d = 1'b1;
         timer_d    = '0;
      end

      in_ready_d = (state_d == S_LEN) || (state_d == S_LOW) ||
                   (state_d == S_HIGH) || (state_d == S_CHK);
   end

   // State and output registers; reset drops any pending write and holds the CPU.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= S_IDLE;
         in_ready_q     <= 1'b0;
         imem_we_q      <= 1'b0;
         imem_waddr_q   <= '0;
         imem_wdata_q   <= '0;
         cpu_hold_q     <= 1'b1;
         done_q         <= 1'b0;
         error_q        <= 1'b0;
         words_loaded_q <= '0;
         len_q          <= '0;
         low_q          <= '0;
         addr_q         <= '0;
         sum_q          <= '0;
         timer_q        <= '0;
      end else begin
         // NOTE: non-blocking updates so every flop samples the pre-edge values.
         state_q        <= state_d;
         in_ready_q     <= in_ready_d;
         imem_we_q      <= imem_we_d;
         imem_waddr_q   <= imem_waddr_d;
         imem_wdata_q   <= imem_wdata_d;
         cpu_hold_q     <= cpu_hold_d;
         done_q         <= done_d;
         error_q        <= error_d;
         words_loaded_q <= words_loaded_d;
         len_q          <= len_d;
         low_q          <= low_d;
         addr_q         <= addr_d;
         sum_q          <= sum_d;
         timer_q        <= timer_d;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_waddr   = imem_waddr_q;
   assign imem_wdata   = imem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign error        = error_q;
   assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_imem_program_loader.sv
// Scoreboard bench for imem_program_loader: stimulus pushes expected writes
// and frame outcomes; a monitor pops and compares as the DUT presents them.
module tb_imem_program_loader;

   localparam int AW = 4;
   localparam int TO = 8;

   typedef logic [7:0] bytes_t[$];
   typedef struct packed {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;
   typedef struct packed {
      logic        done;
      logic        error;
      logic [AW:0] words;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          in_valid;
   logic [7:0]    in_data;
   logic          in_ready;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [15:0]   imem_wdata;
   logic          cpu_hold;
   logic          done;
   logic          error;
   logic [AW:0]   words_loaded;

   wr_t  wr_q[$];
   res_t res_q[$];
   int   tests = 0;
   int   fails = 0;

   imem_program_loader #(
      .IMEM_AW    (AW),
      .INSTR_W    (16),
      .TIMEOUT_CYC(TO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .imem_we     (imem_we),
      .imem_waddr  (imem_waddr),
      .imem_wdata  (imem_wdata),
      .cpu_hold    (cpu_hold),
      .done        (done),
      .error       (error),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n;
      n = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         check("in_ready_wait", in_ready, 1);
         in_valid = 1'b0;
      end else begin
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic send_seq(input bytes_t b);
      foreach (b[i]) send_byte(b[i]);
   endtask

   task automatic expect_two_words();
      wr_q.push_back('{addr: 4'h0, data: 16'h1234});
      wr_q.push_back('{addr: 4'h1, data: 16'h5678});
   endtask

   // Monitor: compare writes and frame outcomes against the scoreboard.
   initial begin
      logic prev_we, prev_flag;
      wr_t  w;
      res_t r;
      prev_we   = 1'b0;
      prev_flag = 1'b0;
      forever begin
         @(negedge clk);
         if (imem_we) begin
            check("we_not_back_to_back", prev_we, 0);
            if (wr_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, expected no write", imem_waddr, imem_wdata);
            end else begin
               w = wr_q.pop_front();
               check("write_addr", imem_waddr, w.addr);
               check("write_data", imem_wdata, w.data);
            end
         end
         if ((done || error) && !prev_flag) begin
            if (res_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_outcome: done %0b error %0b, expected none", done, error);
            end else begin
               r = res_q.pop_front();
               check("outcome_done", done, r.done);
               check("outcome_error", error, r.error);
               check("outcome_words", words_loaded, r.words);
               check("outcome_cpu_hold", cpu_hold, !r.done);
            end
         end
         prev_we   = imem_we;
         prev_flag = done || error;
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bytes_t big;
      logic [7:0] s, lo, hi;

      rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h00;
      #12;
      check("rst_in_ready", in_ready, 0);
      check("rst_imem_we", imem_we, 0);
      check("rst_waddr", imem_waddr, 0);
      check("rst_wdata", imem_wdata, 0);
      check("rst_cpu_hold", cpu_hold, 1);
      check("rst_done", done, 0);
      check("rst_error", error, 0);
      check("rst_words", words_loaded, 0);
      @(negedge clk);
      rst_n = 1'b1;

      // Good two-word frame; checksum 0x34+0x12+0x78+0x56 = 0x114 -> CHK 0xEC.
      expect_two_words();
      res_q.push_back('{done: 1'b1, error: 1'b0, words: 5'd2});
      pulse_start();
      send_seq('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC});
      repeat (2) @(negedge clk);

      // Restart from DONE re-asserts cpu_hold the following cycle.
      pulse_start();
      check("restart_cpu_hold", cpu_hold, 1);
      check("restart_done", done, 0);
      check("restart_words", words_loaded, 0);

      // Bad checksum: both words still written, frame rejected.
      expect_two_words();
      res_q.push_back('{done: 1'b0, error: 1'b1, words: 5'd2});
      send_seq('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hED});
      repeat (2) @(negedge clk);

      // Length bounds: zero and one past capacity are rejected without writes.
      res_q.push_back('{done: 1'b0, error: 1'b1, words: 5'd0});
      pulse_start();
      send_byte(8'h00);
      repeat (2) @(negedge clk);
      res_q.push_back('{done: 1'b0, error: 1'b1, words: 5'd0});
      pulse_start();
      send_byte(8'd17);
      repeat (2) @(negedge clk);
      check("len17_in_ready", in_ready, 0);

      // Full-capacity frame: 16 words, last write at address 15.
      s = 8'h00;
      big.push_back(8'd16);
      for (int i = 0; i < 16; i++) begin
         lo = 8'(i * 17 + 3);
         hi = 8'(8'hC0 ^ i);
         big.push_back(lo);
         big.push_back(hi);
         s = s + lo + hi;
         wr_q.push_back('{addr: 4'(i), data: {hi, lo}});
      end
      big.push_back(8'(-s));
      res_q.push_back('{done: 1'b1, error: 1'b0, words: 5'd16});
      pulse_start();
      send_seq(big);
      repeat (2) @(negedge clk);

      // Seven idle cycles inside a frame are tolerated.
      expect_two_words();
      res_q.push_back('{done: 1'b1, error: 1'b0, words: 5'd2});
      pulse_start();
      send_byte(8'h02);
      repeat (7) @(negedge clk);
      send_seq('{8'h34, 8'h12, 8'h78, 8'h56, 8'hEC});
      repeat (2) @(negedge clk);

      // Eight idle cycles time out.
      res_q.push_back('{done: 1'b0, error: 1'b1, words: 5'd0});
      pulse_start();
      send_byte(8'h02);
      repeat (8) @(negedge clk);
      check("timeout_not_early", error, 0);
      @(negedge clk);
      check("timeout_error", error, 1);
      check("timeout_in_ready", in_ready, 0);

      // start during LOW is ignored.
      expect_two_words();
      res_q.push_back('{done: 1'b1, error: 1'b0, words: 5'd2});
      pulse_start();
      send_byte(8'h02);
      pulse_start();
      check("ignore_start_in_ready", in_ready, 1);
      check("ignore_start_words", words_loaded, 0);
      check("ignore_start_error", error, 0);
      send_seq('{8'h34, 8'h12, 8'h78, 8'h56, 8'hEC});
      repeat (2) @(negedge clk);

      // Asynchronous reset between low and high byte: no write, reset values.
      pulse_start();
      send_seq('{8'h02, 8'h34});
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_in_ready", in_ready, 0);
      check("midrst_cpu_hold", cpu_hold, 1);
      check("midrst_done", done, 0);
      check("midrst_words", words_loaded, 0);
      check("midrst_imem_we", imem_we, 0);
      @(negedge clk);
      rst_n = 1'b1;

      expect_two_words();
      res_q.push_back('{done: 1'b1, error: 1'b0, words: 5'd2});
      pulse_start();
      send_seq('{8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'hEC});
      repeat (4) @(negedge clk);

      check("writes_drained", wr_q.size(), 0);
      check("outcomes_drained", res_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
